// File: rtl/tl_phase_sched.sv
// Demand-driven three-approach phase scheduler. Round-robin arbitration over
// latched requests, green/yellow/all-red sequencing, and emergency preempt.
module tl_phase_sched #(
  parameter int TICK_DIV  = 100000000,
  parameter int GREEN_MIN = 7,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       pre_req,
  input  logic [1:0] pre_dir,
  output logic [2:0] green,
  output logic [2:0] yellow,
  output logic [2:0] red,
  output logic [1:0] phase,
  output logic       preempt_active
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]    GMIN = 8'(GREEN_MIN);
  localparam logic [7:0]    YMAX = 8'(YELLOW_T - 1);
  localparam logic [7:0]    AMAX = 8'(ALLRED_T - 1);

  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_PREEMPT} state_t;

  state_t        state, state_nx;
  logic [1:0]    phase_nx;
  logic [2:0]    pending, pending_nx;
  logic [PW-1:0] presc;
  logic [7:0]    timer, timer_inc;
  logic          tick, entry;
  logic [1:0]    pdir, ph1, ph2;
  logic [2:0]    ph_oh;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign pdir      = (pre_dir == 2'd3) ? 2'd0 : pre_dir;
  assign ph1       = inc3(phase);
  assign ph2       = inc3(ph1);
  assign ph_oh     = 3'b001 << phase;
  assign tick      = (presc == PMAX);
  assign timer_inc = (tick && timer != 8'hFF) ? timer + 8'd1 : timer;

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    case (state)
      S_GREEN: begin
        // Minimum green is judged on the post-tick timer so the green
        // interval spans exactly GREEN_MIN ticks when demand is waiting.
        if (pre_req) state_nx = (pdir == phase) ? S_PREEMPT : S_YELLOW;
        else if (timer_inc >= GMIN && |(pending & ~ph_oh)) state_nx = S_YELLOW;
      end
      S_YELLOW: if (tick && timer == YMAX) state_nx = S_ALLRED;
      S_ALLRED: begin
        if (tick && timer == AMAX) begin
          if (pre_req) begin
            state_nx = S_PREEMPT;
            phase_nx = pdir;
          end else begin
            state_nx = S_GREEN;
            if      (pending[ph1]) phase_nx = ph1;
            else if (pending[ph2]) phase_nx = ph2;
            else                   phase_nx = 2'd0;
          end
        end
      end
      S_PREEMPT: begin
        if (!pre_req)            state_nx = S_GREEN;
        else if (pdir != phase)  state_nx = S_YELLOW;
      end
      default: state_nx = S_GREEN;
    endcase
  end

  assign entry = (state_nx != state) || (phase_nx != phase);

  always_comb begin
    pending_nx = pending | (req & ~green);
    if (entry && (state_nx == S_GREEN || state_nx == S_PREEMPT))
      pending_nx = pending_nx & ~(3'b001 << phase_nx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_GREEN;
      phase   <= 2'd0;
      pending <= 3'b000;
      presc   <= '0;
      timer   <= 8'd0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      pending <= pending_nx;
      if (entry) begin
        presc <= '0;
        timer <= 8'd0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        timer <= timer_inc;
      end
    end
  end

  assign green          = (state == S_GREEN || state == S_PREEMPT) ? ph_oh : 3'b000;
  assign yellow         = (state == S_YELLOW) ? ph_oh : 3'b000;
  assign red            = ~(green | yellow);
  assign preempt_active = (state == S_PREEMPT);

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed bench for tl_phase_sched: rest, single request, round-robin,
// preempt (other and same/invalid direction) and asynchronous reset.
module tb_tl_phase_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       pre_req;
  logic [1:0] pre_dir;
  logic [2:0] green, yellow, red;
  logic [1:0] phase;
  logic       preempt_active;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  tl_phase_sched #(.TICK_DIV(4), .GREEN_MIN(3), .YELLOW_T(2), .ALLRED_T(1)) dut (
    .clk(clk), .rst(rst), .req(req), .pre_req(pre_req), .pre_dir(pre_dir),
    .green(green), .yellow(yellow), .red(red), .phase(phase),
    .preempt_active(preempt_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge, then land on the following falling edge to sample.
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic adv_to(input int n);
    while (cyc < n) adv();
  endtask

  // Leaves the bench at cycle 0: the falling edge right after rst release.
  task automatic do_reset();
    rst = 1'b1; req = 3'b000; pre_req = 1'b0; pre_dir = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req = r;
    adv();
    req = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // Reset values, sampled while rst is still asserted.
    rst = 1'b1; req = 3'b000; pre_req = 1'b0; pre_dir = 2'd0;
    #12;
    chk("rst_green",  green, 3'b001);
    chk("rst_yellow", yellow, 3'b000);
    chk("rst_red",    red, 3'b110);
    chk("rst_phase",  phase, 2'd0);
    chk("rst_pre",    preempt_active, 1'b0);
    chk("rst_pend",   dut.pending, 3'b000);

    // Rest in green with no demand.
    do_reset();
    bad = 0;
    repeat (200) begin
      adv();
      if (green !== 3'b001 || red !== 3'b110 || phase !== 2'd0) bad++;
    end
    chk("rest_hold", bad, 0);

    // Single request on approach 2, pulsed during cycle 5.
    do_reset();
    adv_to(5);
    pulse_req(3'b100);
    chk("sr_pend_set", dut.pending, 3'b100);
    adv_to(11);
    chk("sr_green11",  green, 3'b001);
    adv_to(12);
    chk("sr_yel12",    yellow, 3'b001);
    chk("sr_grn12",    green, 3'b000);
    adv_to(19);
    chk("sr_yel19",    yellow, 3'b001);
    adv_to(20);
    chk("sr_red20",    red, 3'b111);
    adv_to(23);
    chk("sr_red23",    red, 3'b111);
    adv_to(24);
    chk("sr_grn24",    green, 3'b100);
    chk("sr_red24",    red, 3'b011);
    chk("sr_ph24",     phase, 2'd2);
    chk("sr_pend_clr", dut.pending, 3'b000);

    // Round-robin: 1 then 2, then rest on 2 until approach 0 asks.
    do_reset();
    pulse_req(3'b110);
    adv_to(24);
    chk("rr_ph1",      phase, 2'd1);
    chk("rr_grn1",     green, 3'b010);
    chk("rr_pend1",    dut.pending, 3'b100);
    adv_to(47);
    chk("rr_red47",    red, 3'b111);
    adv_to(48);
    chk("rr_ph2",      phase, 2'd2);
    chk("rr_grn2",     green, 3'b100);
    adv_to(60);
    pulse_req(3'b100);
    chk("rr_ign_own",  dut.pending, 3'b000);
    adv_to(88);
    chk("rr_rest2",    green, 3'b100);
    pulse_req(3'b001);
    adv();
    chk("rr_yel90",    yellow, 3'b100);
    adv_to(102);
    chk("rr_ph0",      phase, 2'd0);
    chk("rr_grn0",     green, 3'b001);

    // Preempt to approach 2 from green phase 0 with timer = 1.
    do_reset();
    adv_to(5);
    pre_req = 1'b1; pre_dir = 2'd2;
    adv();
    chk("pe_yel",      yellow, 3'b001);
    chk("pe_act0",     preempt_active, 1'b0);
    adv_to(14);
    chk("pe_allred",   red, 3'b111);
    adv_to(18);
    chk("pe_grn",      green, 3'b100);
    chk("pe_act",      preempt_active, 1'b1);
    bad = 0;
    repeat (50) begin
      adv();
      if (green !== 3'b100 || preempt_active !== 1'b1) bad++;
    end
    chk("pe_hold",     bad, 0);
    pre_req = 1'b0;
    adv();
    chk("pe_drop_grn", green, 3'b100);
    chk("pe_drop_ph",  phase, 2'd2);
    chk("pe_drop_act", preempt_active, 1'b0);

    // Preempt with pre_dir = 3 maps to the current phase 0: no yellow.
    do_reset();
    adv_to(2);
    pre_req = 1'b1; pre_dir = 2'd3;
    adv();
    chk("ps_act",      preempt_active, 1'b1);
    chk("ps_grn",      green, 3'b001);
    chk("ps_yel",      yellow, 3'b000);
    pre_req = 1'b0; pre_dir = 2'd0;
    adv();
    chk("ps_back",     preempt_active, 1'b0);

    // Asynchronous reset in the middle of yellow, between edges.
    do_reset();
    pulse_req(3'b010);
    adv_to(14);
    chk("ar_yel",      yellow, 3'b001);
    req = 3'b100;
    #1;
    rst = 1'b1;
    #1;
    chk("ar_grn",      green, 3'b001);
    chk("ar_red",      red, 3'b110);
    chk("ar_pend",     dut.pending, 3'b000);
    req = 3'b000;
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
Demand-driven phase scheduler for a three-approach intersection (approach 0 = main, 1 = main-turn, 2 = side). It shares the single right-of-way among approach requests using round-robin arbitration, then sequences green, yellow and all-red intervals. An emergency-vehicle preempt overrides the round-robin. The per-approach lamp outputs drive the existing lamp-driver logic directly.

Parameters:
TICK_DIV, 100000000, clk cycles per timing tick (1 s at 100 MHz); must be >= 2.
GREEN_MIN, 7, minimum green duration in ticks, 1..255.
YELLOW_T, 2, yellow duration in ticks, 1..255.
ALLRED_T, 1, all-red clearance duration in ticks, 1..255.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req  in  3  per-approach demand; a single-cycle pulse is sufficient
pre_req  in  1  emergency preempt; level-sensitive, active-high
pre_dir  in  2  approach to serve during preempt; value 3 is treated as 0
green  out  3  green lamp per approach (bit i = approach i)
yellow  out  3  yellow lamp per approach
red  out  3  red lamp per approach
phase  out  2  approach currently owning right-of-way (green or yellow)
preempt_active  out  1  high while in the PREEMPT state

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: state = GREEN, phase = 0, pending = 000, prescaler = 0, timer = 0. Outputs: green = 001, yellow = 000, red = 110, preempt_active = 0.
- Outputs are a Moore decode of the registered state and phase. They change on the same edge as the state.
  - GREEN and PREEMPT: green[phase] = 1.
  - YELLOW: yellow[phase] = 1.
  - ALLRED: green = yellow = 000.
  - Every approach that is not lit green or yellow has red = 1. For every approach i, exactly one of green[i], yellow[i], red[i] is 1.
- Prescaler: counts 0..TICK_DIV-1 and produces a one-cycle tick when it equals TICK_DIV-1. Both the prescaler and timer (8-bit) are cleared on every state entry. A state of D ticks therefore lasts exactly D*TICK_DIV clocks.
- Timer: advances by 1 on each tick. It saturates at 255 and never wraps.
- Pending requests (pending[2:0]):
  - req[i] sets pending[i], except while approach i is green in GREEN or PREEMPT; those requests are ignored.
  - pending[i] clears on the edge that enters GREEN or PREEMPT with phase = i.
  - Set and clear in the same cycle: clear wins.
- State GREEN:
  - If pre_req=1 and effective pre_dir = phase → go to PREEMPT on the next edge.
  - If pre_req=1 and effective pre_dir ≠ phase → go to YELLOW on the next edge. GREEN_MIN is ignored.
  - Otherwise, if timer ≥ GREEN_MIN and any pending[j] with j ≠ phase is set → go to YELLOW.
  - Otherwise stay in GREEN (rest in green indefinitely).
- State YELLOW: on the tick where timer = YELLOW_T-1 → go to ALLRED.
- State ALLRED: on the tick where timer = ALLRED_T-1, select the next phase:
  - If pre_req=1, enter PREEMPT with phase = effective pre_dir.
  - Else, take the first set pending bit searching phase+1, phase+2 (mod 3).
  - If no bit is set, take approach 0.
  - Enter GREEN with the selected phase.
- State PREEMPT:
  - Hold green on phase while pre_req=1.
  - A pre_dir change during PREEMPT → go to YELLOW, then follow the normal ALLRED handling.
  - pre_req falling → go to GREEN with the same phase and the timer cleared.
- pre_req rising during YELLOW or ALLRED: the current interval completes unchanged and is never truncated.
- Reset mid-operation: immediate return to the reset state; all pending requests are lost.

Test Plan:
(Bench parameters: TICK_DIV=4, GREEN_MIN=3, YELLOW_T=2, ALLRED_T=1.)
- Rest: release rst and apply no req for 200 clks → green=001, red=110, phase=0 held constant throughout.
- Single request: after rst release (cycle 0), pulse req=100 at cycle 5.
  - green=001 until cycle 12, yellow=001 cycles 12–19, all lamps red cycles 20–23.
  - green=100 and phase=2 from cycle 24; pending[2] = 0 afterwards.
- Round-robin: pulse req=110 while phase 0 is green → serves phase 1, then phase 2 (after GREEN_MIN), then returns to phase 0 only if req[0] was pulsed.
- Preempt override: in GREEN phase 0 at timer=1, raise pre_req with pre_dir=2 → YELLOW on the next edge, ALLRED, then PREEMPT on phase 2 with preempt_active=1.
  - Holds for 50 clks.
  - On pre_req drop → GREEN phase 2 with preempt_active=0.
- Preempt same phase / invalid dir: pre_req=1 with pre_dir=3 while phase 0 is green → PREEMPT on the next edge with no yellow; green remains 001.
- Async reset: assert rst mid-YELLOW, between clock edges → outputs return to green=001, red=110 before the next clk edge; pending=000.
